bram_port_arbiter: RTL and testbench

Shares the single-port frame-buffer BRAM between the RX capture path (writer) and the TX/VGA scan-out path (reader).
- TX reads have absolute priority so scan-out timing is never disturbed.
- RX writes are queued in a small FIFO and drained into the BRAM on any cycle where TX is not reading: horizontal/vertical blanking, or the gaps TX leaves.
- Sits between the RX/TX modules and the BRAM primitive, and replaces their direct BRAM connections.

---
 rtl/bram_port_arbiter.sv | 107 ++++++++++
 tb/tb_bram_port_arbiter.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/bram_port_arbiter.sv
// rtl/bram_port_arbiter.sv - single-port frame-buffer BRAM shared by TX scan-out reads and FIFO-queued RX writes
// TX reads always win the port; RX writes wait in a 2^FIFO_AW deep FIFO and drain in free cycles.
module bram_port_arbiter #(
   parameter int ADDR_W  = 14,
   parameter int DATA_W  = 8,
   parameter int FIFO_AW = 4
) (
   input  logic                CLK,
   input  logic                RESET,
   input  logic                RD_EN,
   input  logic [ADDR_W-1:0]   RD_ADDR,
   output logic [DATA_W-1:0]   RD_DATA,
   output logic                RD_VALID,
   input  logic                WR_VALID,
   input  logic [ADDR_W-1:0]   WR_ADDR,
   input  logic [DATA_W-1:0]   WR_DATA,
   output logic                WR_READY,
   output logic [ADDR_W-1:0]   BRAM_ADDR,
   output logic [DATA_W-1:0]   BRAM_DIN,
   output logic                BRAM_WE,
   input  logic [DATA_W-1:0]   BRAM_DOUT,
   output logic [FIFO_AW:0]    FIFO_LEVEL,
   output logic                OVERFLOW,
   output logic [15:0]         DROP_COUNT,
   input  logic                CLEAR_STATS
);

   localparam int DEPTH = 1 << FIFO_AW;

   logic [ADDR_W+DATA_W-1:0] mem [0:DEPTH-1];
   logic [FIFO_AW:0]         wr_ptr;
   logic [FIFO_AW:0]         rd_ptr;
   logic                     empty;
   logic                     full;
   logic                     push;
   logic                     pop;
   logic                     drop;
   logic [ADDR_W-1:0]        head_addr;
   logic [DATA_W-1:0]        head_data;

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]) &&
                  (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]);

   assign WR_READY   = !full && !RESET;
   assign push       = WR_VALID && WR_READY;
   assign drop       = WR_VALID && full && !RESET;
   assign pop        = !RD_EN && !empty && !RESET;
   assign FIFO_LEVEL = wr_ptr - rd_ptr;

   assign {head_addr, head_data} = mem[rd_ptr[FIFO_AW-1:0]];

   always_comb begin
      BRAM_ADDR = RD_ADDR;
      BRAM_WE   = 1'b0;
      BRAM_DIN  = head_data;
      if (pop) begin
         BRAM_ADDR = head_addr;
         BRAM_WE   = 1'b1;
      end
   end

   // BRAM read latency is passed straight through to TX.
   assign RD_DATA = BRAM_DOUT;

   always_ff @(posedge CLK) begin
      if (push) begin
         mem[wr_ptr[FIFO_AW-1:0]] <= {WR_ADDR, WR_DATA};
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         RD_VALID <= 1'b0;
      end else begin
         RD_VALID <= RD_EN;
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
      end
   end

   // A drop in the same cycle as CLEAR_STATS is recorded on top of the clear.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         OVERFLOW   <= 1'b0;
         DROP_COUNT <= '0;
      end else if (drop) begin
         OVERFLOW <= 1'b1;
         if (CLEAR_STATS) begin
            DROP_COUNT <= 16'd1;
         end else if (DROP_COUNT != 16'hFFFF) begin
            DROP_COUNT <= DROP_COUNT + 16'd1;
         end
      end else if (CLEAR_STATS) begin
         OVERFLOW   <= 1'b0;
         DROP_COUNT <= '0;
      end
   end

endmodule

// File: tb/tb_bram_port_arbiter.sv
// tb/tb_bram_port_arbiter.sv - self-checking bench for bram_port_arbiter with a queue-based reference model
// Expected BRAM writes and read data are queued as stimulus is applied and compared when the DUT produces them.
module tb_bram_port_arbiter;

   localparam int ADDR_W  = 14;
   localparam int DATA_W  = 8;
   localparam int FIFO_AW = 4;
   localparam int DEPTH   = 16;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              rd_en = 1'b0;
   logic [ADDR_W-1:0] rd_addr = '0;
   logic              wr_valid = 1'b0;
   logic [ADDR_W-1:0] wr_addr = '0;
   logic [DATA_W-1:0] wr_data = '0;
   logic              clr = 1'b0;

   logic [DATA_W-1:0] rd_data;
   logic              rd_valid;
   logic              wr_ready;
   logic [ADDR_W-1:0] bram_addr;
   logic [DATA_W-1:0] bram_din;
   logic              bram_we;
   logic [DATA_W-1:0] bram_dout;
   logic [FIFO_AW:0]  fifo_level;
   logic              overflow;
   logic [15:0]       drop_count;

   always #5 clk = ~clk;

   bram_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIFO_AW(FIFO_AW)) dut (
      .CLK(clk), .RESET(rst),
      .RD_EN(rd_en), .RD_ADDR(rd_addr), .RD_DATA(rd_data), .RD_VALID(rd_valid),
      .WR_VALID(wr_valid), .WR_ADDR(wr_addr), .WR_DATA(wr_data), .WR_READY(wr_ready),
      .BRAM_ADDR(bram_addr), .BRAM_DIN(bram_din), .BRAM_WE(bram_we), .BRAM_DOUT(bram_dout),
      .FIFO_LEVEL(fifo_level), .OVERFLOW(overflow), .DROP_COUNT(drop_count),
      .CLEAR_STATS(clr)
   );

   // Behavioural BRAM with one-cycle registered read.
   logic [DATA_W-1:0] bram_mem [0:(1<<ADDR_W)-1];
   logic [DATA_W-1:0] shadow   [0:(1<<ADDR_W)-1];
   always @(posedge clk) begin
      if (bram_we) bram_mem[bram_addr] <= bram_din;
      bram_dout <= bram_mem[bram_addr];
   end

   typedef struct {
      logic [ADDR_W-1:0] a;
      logic [DATA_W-1:0] d;
   } wr_t;

   wr_t               wq[$];
   logic [DATA_W-1:0] rq[$];
   logic              exp_ovf = 1'b0;
   logic [15:0]       exp_cnt = '0;
   logic              exp_rdv = 1'b0;
   logic              armed = 1'b0;
   int                checks = 0;
   int                errors = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Compare on the falling edge, then advance the model as the next rising edge will.
   always @(negedge clk) begin
      if (armed) begin
         logic exp_we, acc, drp;
         wr_t  h;
         exp_we = !rst && !rd_en && (wq.size() > 0);
         check_eq("bram_we", bram_we, exp_we);
         if (exp_we) begin
            h = wq[0];
            check_eq("bram_addr_wr", bram_addr, h.a);
            check_eq("bram_din", bram_din, h.d);
         end else begin
            check_eq("bram_addr_rd", bram_addr, rd_addr);
         end
         check_eq("wr_ready", wr_ready, !rst && (wq.size() < DEPTH));
         check_eq("fifo_level", fifo_level, wq.size());
         check_eq("overflow", overflow, exp_ovf);
         check_eq("drop_count", drop_count, exp_cnt);
         check_eq("rd_valid", rd_valid, exp_rdv);
         if (exp_rdv && rq.size() > 0) begin
            check_eq("rd_data", rd_data, rq.pop_front());
         end

         if (rst) begin
            wq.delete();
            rq.delete();
            exp_ovf = 1'b0;
            exp_cnt = '0;
            exp_rdv = 1'b0;
         end else begin
            if (rd_en) rq.push_back(shadow[rd_addr]);
            acc = wr_valid && (wq.size() < DEPTH);
            drp = wr_valid && !acc;
            if (exp_we) begin
               h = wq.pop_front();
               shadow[h.a] = h.d;
            end
            if (acc) wq.push_back('{a: wr_addr, d: wr_data});
            if (drp) begin
               exp_ovf = 1'b1;
               if (clr) exp_cnt = 16'd1;
               else if (exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
            end else if (clr) begin
               exp_ovf = 1'b0;
               exp_cnt = '0;
            end
            exp_rdv = rd_en;
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      rd_en = 1'b0; wr_valid = 1'b0; clr = 1'b0;
      repeat (n) step();
   endtask

   initial begin
      for (int i = 0; i < (1 << ADDR_W); i++) begin
         bram_mem[i] = '0;
         shadow[i]   = '0;
      end
      @(posedge clk);
      armed = 1'b1;
      #1;
      step();
      rst = 1'b0;
      idle(3);

      // single write during blanking, then read it back
      wr_valid = 1'b1; wr_addr = 14'h0123; wr_data = 8'hA5;
      step();
      idle(3);
      rd_en = 1'b1; rd_addr = 14'h0123;
      step();
      idle(2);

      // read priority: five writes held off by ten read cycles
      for (int i = 0; i < 10; i++) begin
         rd_en = 1'b1; rd_addr = 14'(14'h0200 + i);
         wr_valid = (i < 5);
         wr_addr = 14'(14'h0100 + i); wr_data = 8'(8'h10 + i);
         step();
      end
      idle(7);
      for (int i = 0; i < 5; i++) begin
         rd_en = 1'b1; rd_addr = 14'(14'h0100 + i);
         step();
      end
      idle(2);

      // overflow under continuous reads, clear, then clear colliding with a drop
      for (int i = 0; i < 20; i++) begin
         rd_en = 1'b1; rd_addr = 14'(i);
         wr_valid = 1'b1; wr_addr = 14'(14'h0300 + i); wr_data = 8'(8'h40 + i);
         step();
      end
      wr_valid = 1'b0; clr = 1'b1;
      step();
      wr_valid = 1'b1; clr = 1'b1;
      step();
      idle(20);

      // simultaneous push and pop at level 3
      for (int i = 0; i < 3; i++) begin
         rd_en = 1'b1; wr_valid = 1'b1;
         wr_addr = 14'(14'h0400 + i); wr_data = 8'(8'h80 + i);
         step();
      end
      for (int i = 3; i < 11; i++) begin
         rd_en = 1'b0; wr_valid = 1'b1;
         wr_addr = 14'(14'h0400 + i); wr_data = 8'(8'h80 + i);
         step();
      end
      idle(5);

      // reset mid-drain discards eight queued writes
      for (int i = 0; i < 8; i++) begin
         rd_en = 1'b1; wr_valid = 1'b1;
         wr_addr = 14'(14'h0500 + i); wr_data = 8'(8'hC0 + i);
         step();
      end
      rd_en = 1'b0; wr_valid = 1'b0; rst = 1'b1;
      step();
      rst = 1'b0;
      idle(4);

      // random traffic over a small address window to exercise same-address hazards
      for (int i = 0; i < 200; i++) begin
         rd_en    = ($urandom_range(0, 9) < 6);
         rd_addr  = 14'($urandom_range(0, 15));
         wr_valid = ($urandom_range(0, 1) == 1);
         wr_addr  = 14'($urandom_range(0, 15));
         wr_data  = 8'($urandom_range(0, 255));
         clr      = ($urandom_range(0, 19) == 0);
         step();
      end
      idle(20);
      for (int i = 0; i < 16; i++) begin
         rd_en = 1'b1; rd_addr = 14'(i);
         step();
      end
      idle(3);

      check_eq("final_wq_empty", wq.size(), 0);
      check_eq("final_rq_empty", rq.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
